// File: rtl/wb_queue_if.sv
// Request/retire/hazard bundle between the write-back queue and its producers,
// the register file write port and the hazard logic.
interface wb_queue_if #(
  parameter int DW = 16,
  parameter int AW = 4
);
  logic                 alu_valid;
  logic [AW-1:0]        alu_addr;
  logic [DW-1:0]        alu_data;
  logic                 alu_ready;
  logic                 mem_valid;
  logic [AW-1:0]        mem_addr;
  logic [DW-1:0]        mem_data;
  logic                 mem_ready;
  logic                 hold;
  logic                 Load;
  logic [AW-1:0]        Caddr;
  logic [DW-1:0]        C;
  logic [(1<<AW)-1:0]   pending;
  logic [AW-1:0]        fwd_addr;
  logic                 fwd_hit;
  logic [DW-1:0]        fwd_data;
  logic                 full;
  logic                 empty;

  modport master (
    output alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data, hold, fwd_addr,
    input  alu_ready, mem_ready, Load, Caddr, C, pending, fwd_hit, fwd_data, full, empty
  );

  modport slave (
    input  alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data, hold, fwd_addr,
    output alu_ready, mem_ready, Load, Caddr, C, pending, fwd_hit, fwd_data, full, empty
  );
endinterface

// File: rtl/wb_queue.sv
// In-order write-back FIFO in front of the register file write port, with pending mask
// and newest-entry forwarding. Optional R0_ZERO_EN: writes to register 0 are dropped.
module wb_queue #(
  parameter int DEPTH = 4,
  parameter int DW    = 16,
  parameter int AW    = 4
) (
  input logic       clk,
  input logic       Clear,
  wb_queue_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int NR = 1 << AW;

  logic [AW-1:0]    addr_q [DEPTH];
  logic [AW-1:0]    addr_d [DEPTH];
  logic [DW-1:0]    data_q [DEPTH];
  logic [DW-1:0]    data_d [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic             load_q, load_d;
  logic [AW-1:0]    caddr_q, caddr_d;
  logic [DW-1:0]    c_q, c_d;

  logic             full, empty, do_push, store, pop;
  logic [AW-1:0]    push_addr;
  logic [DW-1:0]    push_data;
  logic [NR-1:0]    pend;
  logic             hit;
  logic [DW-1:0]    fdata;
  logic [PW-1:0]    idx;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  // Ready looks only at the current count, so a full queue refuses even while popping.
  always_comb begin
    push_addr = bus.mem_valid ? bus.mem_addr : bus.alu_addr;
    push_data = bus.mem_valid ? bus.mem_data : bus.alu_data;
    do_push   = (bus.mem_valid || bus.alu_valid) && !full;
`ifdef R0_ZERO_EN
    store     = do_push && (push_addr != '0);
`else
    store     = do_push;
`endif
    pop       = !bus.hold && !empty;
  end

  always_comb begin
    addr_d  = addr_q;
    data_d  = data_q;
    valid_d = valid_q;
    head_d  = head_q;
    tail_d  = tail_q;
    load_d  = 1'b0;
    caddr_d = caddr_q;
    c_d     = c_q;
    if (pop) begin
      load_d          = 1'b1;
      caddr_d         = addr_q[head_q];
      c_d             = data_q[head_q];
      valid_d[head_q] = 1'b0;
      head_d          = head_q + 1'b1;
    end
    if (store) begin
      addr_d[tail_q]  = push_addr;
      data_d[tail_q]  = push_data;
      valid_d[tail_q] = 1'b1;
      tail_d          = tail_q + 1'b1;
    end
    count_d = count_q + CW'(store) - CW'(pop);
  end

  // Walk oldest to newest so the most recently accepted match overrides older ones.
  always_comb begin
    pend  = '0;
    hit   = 1'b0;
    fdata = '0;
    idx   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_q + PW'(k);
      if (valid_q[idx]) begin
        pend[addr_q[idx]] = 1'b1;
        if (addr_q[idx] == bus.fwd_addr) begin
          hit   = 1'b1;
          fdata = data_q[idx];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge Clear) begin
    if (Clear) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      load_q  <= 1'b0;
      caddr_q <= '0;
      c_q     <= '0;
    end else begin
      addr_q  <= addr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      load_q  <= load_d;
      caddr_q <= caddr_d;
      c_q     <= c_d;
    end
  end

  assign bus.mem_ready = !full;
  assign bus.alu_ready = !full && !bus.mem_valid;
  assign bus.full      = full;
  assign bus.empty     = empty;
  assign bus.pending   = pend;
  assign bus.fwd_hit   = hit;
  assign bus.fwd_data  = fdata;
  assign bus.Load      = load_q;
  assign bus.Caddr     = caddr_q;
  assign bus.C         = c_q;
endmodule

// File: tb/tb_wb_queue.sv
// Bench for wb_queue: directed scenarios plus random traffic, all checked against a
// queue-based reference model of the write-back queue.
module tb_wb_queue;
  localparam int DEPTH = 4;
  localparam int DW    = 16;
  localparam int AW    = 4;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  logic clk = 1'b0;
  logic Clear;
  int   errors = 0;
  int   checks = 0;

  ent_t          q[$];
  logic          m_load;
  logic [AW-1:0] m_caddr;
  logic [DW-1:0] m_c;

  always #5 clk = ~clk;

  wb_queue_if #(.DW(DW), .AW(AW)) bus ();

  wb_queue #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
    .clk  (clk),
    .Clear(Clear),
    .bus  (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                       input logic mv, input logic [AW-1:0] ma, input logic [DW-1:0] md,
                       input logic h, input logic [AW-1:0] fa);
    bus.alu_valid = av; bus.alu_addr = aa; bus.alu_data = ad;
    bus.mem_valid = mv; bus.mem_addr = ma; bus.mem_data = md;
    bus.hold = h; bus.fwd_addr = fa;
  endtask

  function automatic bit model_drops(input logic [AW-1:0] a);
`ifdef R0_ZERO_EN
    return a == '0;
`else
    return 1'b0;
`endif
  endfunction

  // One clock: check combinational outputs against the model, advance both across
  // the edge, then check the registered write port.
  task automatic step();
    logic [(1<<AW)-1:0] pend;
    logic               hit, mr, ar;
    logic [DW-1:0]      fd;
    ent_t               e;
    #2;
    mr = (q.size() < DEPTH);
    ar = mr && !bus.mem_valid;
    pend = '0; hit = 1'b0; fd = '0;
    foreach (q[i]) begin
      pend[q[i].a] = 1'b1;
      if (q[i].a == bus.fwd_addr) begin hit = 1'b1; fd = q[i].d; end
    end
    chk("mem_ready", 32'(bus.mem_ready), 32'(mr));
    chk("alu_ready", 32'(bus.alu_ready), 32'(ar));
    chk("full",      32'(bus.full),      32'(q.size() == DEPTH));
    chk("empty",     32'(bus.empty),     32'(q.size() == 0));
    chk("pending",   32'(bus.pending),   32'(pend));
    chk("fwd_hit",   32'(bus.fwd_hit),   32'(hit));
    chk("fwd_data",  32'(bus.fwd_data),  32'(fd));
    @(posedge clk);
    if (!bus.hold && q.size() > 0) begin
      e = q.pop_front();
      m_load = 1'b1; m_caddr = e.a; m_c = e.d;
    end else begin
      m_load = 1'b0;
    end
    if (mr && (bus.mem_valid || bus.alu_valid)) begin
      e.a = bus.mem_valid ? bus.mem_addr : bus.alu_addr;
      e.d = bus.mem_valid ? bus.mem_data : bus.alu_data;
      if (!model_drops(e.a)) q.push_back(e);
    end
    #1;
    chk("Load",  32'(bus.Load),  32'(m_load));
    chk("Caddr", 32'(bus.Caddr), 32'(m_caddr));
    chk("C",     32'(bus.C),     32'(m_c));
  endtask

  initial begin
    Clear = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    m_load = 1'b0; m_caddr = '0; m_c = '0;
    #3;
    chk("rst_empty",   32'(bus.empty),   32'd1);
    chk("rst_full",    32'(bus.full),    32'd0);
    chk("rst_load",    32'(bus.Load),    32'd0);
    chk("rst_c",       32'(bus.C),       32'd0);
    chk("rst_pending", 32'(bus.pending), 32'd0);
    @(posedge clk); #1;
    Clear = 1'b0;

    // Single write
    drive(1, 5, 16'h1234, 0, 0, 0, 0, 5);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 5);
    #1 chk("t1_pending5", 32'(bus.pending[5]), 32'd1);
    step();
    chk("t1_load",  32'(bus.Load),  32'd1);
    chk("t1_caddr", 32'(bus.Caddr), 32'd5);
    chk("t1_c",     32'(bus.C),     32'h1234);
    step();
    chk("t1_load_low", 32'(bus.Load), 32'd0);

    // Load path has priority; ALU stays valid until taken
    drive(1, 3, 16'hAAAA, 1, 4, 16'hBBBB, 0, 0);
    #1 chk("t2_aready", 32'(bus.alu_ready), 32'd0);
    step();
    drive(1, 3, 16'hAAAA, 0, 0, 0, 0, 0);
    #1 chk("t2_aready2", 32'(bus.alu_ready), 32'd1);
    step();
    chk("t2_first", 32'(bus.Caddr), 32'd4);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    chk("t2_second", 32'(bus.Caddr), 32'd3);
    step();

    // Fill while holding, fifth request refused
    for (int i = 0; i < 5; i++) begin
      drive(1, AW'(i + 8), DW'($urandom), 0, 0, 0, 1, 0);
      step();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("t3_full", 32'(bus.full), 32'd1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t3_drain_addr", 32'(bus.Caddr), 32'(i + 8));
    end
    step();
    chk("t3_empty", 32'(bus.empty), 32'd1);

    // Newest matching entry forwards
    drive(1, 7, 16'h1111, 0, 0, 0, 1, 7); step();
    drive(1, 7, 16'h2222, 0, 0, 0, 1, 7); step();
    drive(0, 0, 0, 0, 0, 0, 1, 7);
    #1 chk("t4_hit", 32'(bus.fwd_hit), 32'd1);
    chk("t4_data", 32'(bus.fwd_data), 32'h2222);
    bus.fwd_addr = 8;
    #1 chk("t4_miss", 32'(bus.fwd_hit), 32'd0);
    chk("t4_miss_data", 32'(bus.fwd_data), 32'd0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) step();

    // Clear mid-run discards queued writes
    for (int i = 0; i < 3; i++) begin
      drive(1, AW'(i + 1), DW'($urandom), 0, 0, 0, 1, 0);
      step();
    end
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    Clear = 1'b1;
    #1;
    chk("t5_empty",   32'(bus.empty),   32'd1);
    chk("t5_pending", 32'(bus.pending), 32'd0);
    chk("t5_load",    32'(bus.Load),    32'd0);
    chk("t5_c",       32'(bus.C),       32'd0);
    Clear = 1'b0;
    q.delete(); m_load = 1'b0; m_caddr = '0; m_c = '0;
    bus.hold = 1'b0;
    repeat (4) begin
      step();
      chk("t5_no_load", 32'(bus.Load), 32'd0);
    end

    // Register 0 destination
    drive(1, 0, 16'hFFFF, 0, 0, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
`ifdef R0_ZERO_EN
    #1 chk("t6_pend0", 32'(bus.pending[0]), 32'd0);
    chk("t6_hit0", 32'(bus.fwd_hit), 32'd0);
    step();
    chk("t6_no_load", 32'(bus.Load), 32'd0);
`else
    #1 chk("t6_pend0", 32'(bus.pending[0]), 32'd1);
    step();
    chk("t6_load",  32'(bus.Load),  32'd1);
    chk("t6_caddr", 32'(bus.Caddr), 32'd0);
    chk("t6_c",     32'(bus.C),     32'hFFFF);
`endif
    step();

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom),
            1'($urandom_range(0, 2) == 0), AW'($urandom), DW'($urandom),
            1'($urandom_range(0, 2) == 0), AW'($urandom));
      step();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (DEPTH + 1) step();
    chk("final_empty", 32'(bus.empty), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
